// File: rtl/main_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_bus_master_pkg
// Brief    : Shared types and defaults for the main-bus master stage.
// Revision : 1.0 - initial release
// ============================================================================
package main_bus_master_pkg;

    localparam int C_DATA_W_DEF    = 16;
    localparam int C_BURST_LEN_DEF = 4;
    localparam int C_PAGE_W        = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        DATA = 3'd3,
        RESP = 3'd4
    } state_t;

    typedef logic [C_BURST_LEN_DEF-1:0][C_DATA_W_DEF-1:0] burst_t;

endpackage
`default_nettype wire

// File: rtl/main_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : main_bus_master_if
// Brief    : Request/response port and main-bus signals of the bus master.
// Revision : 1.0 - initial release
// ============================================================================
interface main_bus_master_if
    import main_bus_master_pkg::*;
#(
    parameter int DATA_W    = C_DATA_W_DEF,
    parameter int BURST_LEN = C_BURST_LEN_DEF
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_rw;
    logic [DATA_W-1:0]             req_addr;
    logic [BURST_LEN*DATA_W-1:0]   req_wdata;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [BURST_LEN*DATA_W-1:0]   resp_rdata;
    logic                          resp_err;
    logic                          bus_addr_valid;
    logic                          bus_rw;
    logic [DATA_W-1:0]             bus_ad_out;
    logic                          bus_ad_oe;
    logic [DATA_W-1:0]             bus_ad_in;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata, resp_ready, bus_ad_in,
        output req_ready, resp_valid, resp_rdata, resp_err,
               bus_addr_valid, bus_rw, bus_ad_out, bus_ad_oe
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata, resp_ready, bus_ad_in,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               bus_addr_valid, bus_rw, bus_ad_out, bus_ad_oe
    );

endinterface
`default_nettype wire

// File: rtl/main_bus_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : main_bus_beat_counter
// Brief    : Loadable down-counter with a zero flag for wait and data phases.
// Revision : 1.0 - initial release
// ============================================================================
module main_bus_beat_counter #(
    parameter int CNT_W = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             en,
    output logic      [CNT_W-1:0] count,
    output logic                  done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/main_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : main_bus_master
// Brief    : Burst request to multiplexed main-bus master FSM.
//            Optional page check: MAIN_BUS_MASTER_ADDR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module main_bus_master
    import main_bus_master_pkg::*;
#(
    parameter int                  DATA_W    = C_DATA_W_DEF,
    parameter int                  BURST_LEN = C_BURST_LEN_DEF,
    parameter int                  READ_LAT  = 0,
    parameter logic [C_PAGE_W-1:0] MEM_PAGE  = 4'h2
) (
    input  wire logic           clk,
    input  wire logic           resetN,
    main_bus_master_if.master   bif
);

    localparam int C_MAX_CNT = (BURST_LEN > READ_LAT) ? BURST_LEN : READ_LAT;
    localparam int C_CNT_W   = $clog2(C_MAX_CNT + 1);
    localparam int C_IDX_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [C_CNT_W-1:0] C_BEAT_LOAD = C_CNT_W'(BURST_LEN - 1);
    localparam logic [C_CNT_W-1:0] C_LAT_LOAD  =
        (READ_LAT > 0) ? C_CNT_W'(READ_LAT - 1) : '0;

    state_t                          state_q, state_d;
    logic                            rw_q, rw_d;
    logic                            err_q, err_d;
    logic [DATA_W-1:0]               addr_q, addr_d;
    logic [BURST_LEN-1:0][DATA_W-1:0] wdata_q, wdata_d;
    logic [BURST_LEN-1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic               cnt_load, cnt_en, cnt_done;
    logic [C_CNT_W-1:0] cnt_load_val, cnt_value;
    logic [C_IDX_W-1:0] beat_idx;
    logic               page_hit, reject;

    main_bus_beat_counter #(.CNT_W(C_CNT_W)) u_beat_counter (
        .clk      (clk),
        .rst_n    (resetN),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .count    (cnt_value),
        .done     (cnt_done)
    );

    // The counter runs down, so the beat index is its distance from the load value.
    assign beat_idx = C_IDX_W'(C_BEAT_LOAD - cnt_value);
    assign page_hit = (bif.req_addr[DATA_W-1 -: C_PAGE_W] == MEM_PAGE);

`ifdef MAIN_BUS_MASTER_ADDR_CHECK_EN
    assign reject = !page_hit;
`else
    logic unused_page_hit;
    assign unused_page_hit = page_hit;
    assign reject          = 1'b0;
`endif

    always_comb begin
        state_d            = state_q;
        rw_d               = rw_q;
        err_d              = err_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        rdata_d            = rdata_q;
        cnt_load           = 1'b0;
        cnt_en             = 1'b0;
        cnt_load_val       = C_BEAT_LOAD;
        bif.req_ready      = 1'b0;
        bif.resp_valid     = 1'b0;
        bif.bus_addr_valid = 1'b0;
        bif.bus_rw         = 1'b0;
        bif.bus_ad_out     = '0;
        bif.bus_ad_oe      = 1'b0;
        case (state_q)
            IDLE: begin
                bif.req_ready = 1'b1;
                if (bif.req_valid) begin
                    rw_d    = bif.req_rw;
                    addr_d  = bif.req_addr;
                    wdata_d = bif.req_wdata;
                    rdata_d = '0;
                    err_d   = reject;
                    state_d = reject ? RESP : ADDR;
                end
            end
            ADDR: begin
                bif.bus_addr_valid = 1'b1;
                bif.bus_ad_oe      = 1'b1;
                bif.bus_ad_out     = addr_q;
                bif.bus_rw         = rw_q;
                cnt_load           = 1'b1;
                if (!rw_q || (READ_LAT == 0)) begin
                    state_d = DATA;
                end else begin
                    cnt_load_val = C_LAT_LOAD;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                bif.bus_rw = rw_q;
                cnt_en     = 1'b1;
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                bif.bus_rw = rw_q;
                cnt_en     = 1'b1;
                if (!rw_q) begin
                    bif.bus_ad_oe  = 1'b1;
                    bif.bus_ad_out = wdata_q[beat_idx];
                end else begin
                    rdata_d[beat_idx] = bif.bus_ad_in;
                end
                if (cnt_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bif.resp_valid = 1'b1;
                if (bif.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bif.resp_rdata = rdata_q;
    assign bif.resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_main_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_bus_master
// Brief    : Directed self-checking bench for main_bus_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_bus_master;
    import main_bus_master_pkg::*;

    logic clk = 1'b0;
    logic resetN;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    main_bus_master_if #(.DATA_W(16), .BURST_LEN(4)) bif0 ();
    main_bus_master_if #(.DATA_W(16), .BURST_LEN(4)) bif1 ();

    main_bus_master #(.DATA_W(16), .BURST_LEN(4), .READ_LAT(0), .MEM_PAGE(4'h2)) dut0 (
        .clk(clk), .resetN(resetN), .bif(bif0)
    );
    main_bus_master #(.DATA_W(16), .BURST_LEN(4), .READ_LAT(2), .MEM_PAGE(4'h2)) dut1 (
        .clk(clk), .resetN(resetN), .bif(bif1)
    );

    task automatic idle_inputs();
        bif0.req_valid = 0; bif0.req_rw = 0; bif0.req_addr = '0; bif0.req_wdata = '0;
        bif0.resp_ready = 0; bif0.bus_ad_in = '0;
        bif1.req_valid = 0; bif1.req_rw = 0; bif1.req_addr = '0; bif1.req_wdata = '0;
        bif1.resp_ready = 0; bif1.bus_ad_in = '0;
    endtask

    // Presents one request for a single cycle; returns at the ADDR-cycle negedge.
    task automatic send_req(input int unit, input logic rw, input logic [15:0] addr,
                            input burst_t wd);
        if (unit == 0) begin
            bif0.req_valid = 1; bif0.req_rw = rw; bif0.req_addr = addr; bif0.req_wdata = wd;
        end else begin
            bif1.req_valid = 1; bif1.req_rw = rw; bif1.req_addr = addr; bif1.req_wdata = wd;
        end
        @(negedge clk);
        bif0.req_valid = 0;
        bif1.req_valid = 0;
    endtask

    task automatic finish_resp(input int unit);
        if (unit == 0) bif0.resp_ready = 1; else bif1.resp_ready = 1;
        @(negedge clk);
        bif0.resp_ready = 0;
        bif1.resp_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bif0.req_ready, bif0.resp_valid, bif0.resp_err, bif0.bus_addr_valid,
             bif0.bus_rw, bif0.bus_ad_oe} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000", {bif0.req_ready, bif0.resp_valid,
                     bif0.resp_err, bif0.bus_addr_valid, bif0.bus_rw, bif0.bus_ad_oe});
        end
        checks++;
        if (bif0.bus_ad_out !== 16'h0 || bif0.resp_rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: ad_out=%h rdata=%h want 0", bif0.bus_ad_out, bif0.resp_rdata);
        end
        checks++;
        if (bif1.req_ready !== 1'b1 || bif1.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: ready=%b valid=%b want 1/0", bif1.req_ready, bif1.resp_valid);
        end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        burst_t wd = {16'hD, 16'hC, 16'hB, 16'hA};
        checks++;
        if (bif0.req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_ready: got %b want 1", bif0.req_ready);
        end
        send_req(0, 1'b0, 16'h2010, wd);
        checks++;
        if ({bif0.bus_addr_valid, bif0.bus_ad_oe, bif0.bus_rw, bif0.req_ready} !== 4'b1100 ||
            bif0.bus_ad_out !== 16'h2010) begin
            errors++;
            $display("FAIL wr_addr: av/oe/rw/rdy=%b ad=%h want 1100/2010", {bif0.bus_addr_valid,
                     bif0.bus_ad_oe, bif0.bus_rw, bif0.req_ready}, bif0.bus_ad_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bif0.bus_addr_valid, bif0.bus_ad_oe, bif0.resp_valid} !== 3'b010 ||
                bif0.bus_ad_out !== wd[i]) begin
                errors++;
                $display("FAIL wr_beat%0d: av/oe/rv=%b ad=%h want 010/%h", i,
                         {bif0.bus_addr_valid, bif0.bus_ad_oe, bif0.resp_valid}, bif0.bus_ad_out, wd[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bif0.resp_valid !== 1'b1 || bif0.resp_err !== 1'b0 || bif0.resp_rdata !== 64'h0 ||
            bif0.bus_ad_oe !== 1'b0 || bif0.bus_rw !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp: rv=%b err=%b rdata=%h oe=%b rw=%b want 1/0/0/0/0",
                     bif0.resp_valid, bif0.resp_err, bif0.resp_rdata, bif0.bus_ad_oe, bif0.bus_rw);
        end
        finish_resp(0);
        checks++;
        if (bif0.req_ready !== 1'b1 || bif0.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: ready=%b rv=%b want 1/0", bif0.req_ready, bif0.resp_valid);
        end
    endtask

    task automatic test_read_lat0();
        burst_t exp = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        send_req(0, 1'b1, 16'h2100, '0);
        checks++;
        if (bif0.bus_addr_valid !== 1'b1 || bif0.bus_rw !== 1'b1 || bif0.bus_ad_out !== 16'h2100) begin
            errors++;
            $display("FAIL rd0_addr: av=%b rw=%b ad=%h want 1/1/2100",
                     bif0.bus_addr_valid, bif0.bus_rw, bif0.bus_ad_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bif0.bus_ad_in = exp[i];
            checks++;
            if ({bif0.bus_ad_oe, bif0.bus_rw, bif0.resp_valid} !== 3'b010) begin
                errors++;
                $display("FAIL rd0_beat%0d: oe/rw/rv=%b want 010", i,
                         {bif0.bus_ad_oe, bif0.bus_rw, bif0.resp_valid});
            end
        end
        @(negedge clk);
        bif0.bus_ad_in = 16'hFFFF;
        checks++;
        if (bif0.resp_valid !== 1'b1 || bif0.resp_rdata !== exp) begin
            errors++;
            $display("FAIL rd0_resp: rv=%b rdata=%h want 1/%h", bif0.resp_valid, bif0.resp_rdata, exp);
        end
        finish_resp(0);
    endtask

    task automatic test_read_lat2();
        burst_t exp = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
        send_req(1, 1'b1, 16'h2200, '0);
        checks++;
        if (bif1.bus_addr_valid !== 1'b1 || bif1.bus_ad_out !== 16'h2200) begin
            errors++;
            $display("FAIL rd2_addr: av=%b ad=%h want 1/2200", bif1.bus_addr_valid, bif1.bus_ad_out);
        end
        repeat (2) begin
            @(negedge clk);
            bif1.bus_ad_in = 16'hDEAD;
            checks++;
            if ({bif1.bus_addr_valid, bif1.bus_ad_oe, bif1.bus_rw, bif1.resp_valid} !== 4'b0010) begin
                errors++;
                $display("FAIL rd2_wait: av/oe/rw/rv=%b want 0010",
                         {bif1.bus_addr_valid, bif1.bus_ad_oe, bif1.bus_rw, bif1.resp_valid});
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bif1.bus_ad_in = exp[i];
            checks++;
            if (bif1.resp_valid !== 1'b0 || bif1.bus_ad_oe !== 1'b0) begin
                errors++;
                $display("FAIL rd2_beat%0d: rv=%b oe=%b want 0/0", i, bif1.resp_valid, bif1.bus_ad_oe);
            end
        end
        @(negedge clk);
        bif1.bus_ad_in = '0;
        checks++;
        if (bif1.resp_valid !== 1'b1 || bif1.resp_rdata !== exp) begin
            errors++;
            $display("FAIL rd2_resp: rv=%b rdata=%h want 1/%h", bif1.resp_valid, bif1.resp_rdata, exp);
        end
        finish_resp(1);
    endtask

    task automatic test_back_to_back();
        burst_t exp = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
        burst_t wd2 = {16'h9004, 16'h9003, 16'h9002, 16'h9001};
        send_req(0, 1'b1, 16'h2300, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bif0.bus_ad_in = exp[i];
        end
        @(negedge clk);
        bif0.bus_ad_in = 16'h0;
        for (int k = 0; k < 5; k++) begin
            bif0.req_valid = (k % 2 == 0);
            bif0.req_rw    = 1'b0;
            bif0.req_addr  = 16'h2400 + 16'(k);
            checks++;
            if ({bif0.resp_valid, bif0.req_ready, bif0.bus_addr_valid} !== 3'b100 ||
                bif0.resp_rdata !== exp) begin
                errors++;
                $display("FAIL bp_hold%0d: rv/rdy/av=%b rdata=%h want 100/%h", k,
                         {bif0.resp_valid, bif0.req_ready, bif0.bus_addr_valid}, bif0.resp_rdata, exp);
            end
            @(negedge clk);
        end
        bif0.req_valid = 1'b0;
        finish_resp(0);
        checks++;
        if (bif0.req_ready !== 1'b1 || bif0.bus_addr_valid !== 1'b0 || bif0.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: rdy=%b av=%b rv=%b want 1/0/0",
                     bif0.req_ready, bif0.bus_addr_valid, bif0.resp_valid);
        end
        send_req(0, 1'b0, 16'h2500, wd2);
        checks++;
        if (bif0.bus_addr_valid !== 1'b1 || bif0.bus_ad_out !== 16'h2500) begin
            errors++;
            $display("FAIL b2b_addr: av=%b ad=%h want 1/2500", bif0.bus_addr_valid, bif0.bus_ad_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bif0.bus_ad_oe !== 1'b1 || bif0.bus_ad_out !== wd2[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d: oe=%b ad=%h want 1/%h", i, bif0.bus_ad_oe, bif0.bus_ad_out, wd2[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bif0.resp_valid !== 1'b1 || bif0.resp_rdata !== 64'h0) begin
            errors++;
            $display("FAIL b2b_resp: rv=%b rdata=%h want 1/0", bif0.resp_valid, bif0.resp_rdata);
        end
        finish_resp(0);
    endtask

    task automatic test_reset_mid_data();
        burst_t wd = {16'h6004, 16'h6003, 16'h6002, 16'h6001};
        logic seen;
        send_req(0, 1'b0, 16'h2600, wd);
        repeat (3) @(negedge clk);
        checks++;
        if (bif0.bus_ad_oe !== 1'b1 || bif0.bus_ad_out !== 16'h6003) begin
            errors++;
            $display("FAIL rst_beat2: oe=%b ad=%h want 1/6003", bif0.bus_ad_oe, bif0.bus_ad_out);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if ({bif0.req_ready, bif0.resp_valid, bif0.resp_err, bif0.bus_addr_valid, bif0.bus_rw,
             bif0.bus_ad_oe} !== 6'b100000 || bif0.bus_ad_out !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: ctrl=%b ad=%h want 100000/0", {bif0.req_ready, bif0.resp_valid,
                     bif0.resp_err, bif0.bus_addr_valid, bif0.bus_rw, bif0.bus_ad_oe}, bif0.bus_ad_out);
        end
        @(negedge clk);
        resetN = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | bif0.resp_valid | bif0.bus_addr_valid | bif0.bus_ad_oe;
        end
        checks++;
        if (seen !== 1'b0 || bif0.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: activity=%b rdy=%b want 0/1", seen, bif0.req_ready);
        end
    endtask

    task automatic test_addr_check();
        burst_t wd = {16'h7004, 16'h7003, 16'h7002, 16'h7001};
`ifdef MAIN_BUS_MASTER_ADDR_CHECK_EN
        send_req(0, 1'b1, 16'h5000, '0);
        checks++;
        if ({bif0.resp_valid, bif0.resp_err, bif0.bus_addr_valid, bif0.bus_ad_oe, bif0.bus_rw} !== 5'b11000 ||
            bif0.resp_rdata !== 64'h0) begin
            errors++;
            $display("FAIL chk_reject: rv/err/av/oe/rw=%b rdata=%h want 11000/0", {bif0.resp_valid,
                     bif0.resp_err, bif0.bus_addr_valid, bif0.bus_ad_oe, bif0.bus_rw}, bif0.resp_rdata);
        end
        finish_resp(0);
        send_req(0, 1'b0, 16'h2000, wd);
`else
        send_req(0, 1'b0, 16'h5000, wd);
`endif
        checks++;
        if (bif0.bus_addr_valid !== 1'b1 || bif0.bus_ad_out[11:0] !== 12'h000) begin
            errors++;
            $display("FAIL chk_addr: av=%b ad=%h want 1/x000", bif0.bus_addr_valid, bif0.bus_ad_out);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bif0.resp_valid !== 1'b1 || bif0.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_resp: rv=%b err=%b want 1/0", bif0.resp_valid, bif0.resp_err);
        end
        finish_resp(0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_lat0();
        test_read_lat2();
        test_back_to_back();
        test_reset_mid_data();
        test_addr_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_bus_master.md
Name: main_bus_master

Overview:
- Bus-master stage directly upstream of the memory subsystem slave on the main bus.
- Accepts single burst requests from a processor-side valid/ready port.
- Converts each request into the main-bus protocol: one address cycle with AddrValid, then BURST_LEN data beats on the multiplexed AddrData bus.
- Read data is returned on a held response port.

Parameters:
- DATA_W, 16: width of the multiplexed AddrData bus. Address and data widths are both DATA_W.
- BURST_LEN, 4: data beats per transaction.
- READ_LAT, 0: idle cycles between the address cycle and the first read beat. Writes ignore this parameter.
- MEM_PAGE, 4'h2: page ID (addr[DATA_W-1:DATA_W-4]) that the memory slave owns. Used only with the optional feature.

Ports:
- clk  in  1  single system clock; all logic on posedge
- resetN  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  master can accept a request
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  DATA_W  burst base address
- req_wdata  in  BURST_LEN*DATA_W  write words; word i at [i*DATA_W +: DATA_W]
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  BURST_LEN*DATA_W  read words; zero for writes
- resp_err  out  1  request rejected (optional feature only)
- bus_addr_valid  out  1  main-bus AddrValid
- bus_rw  out  1  main-bus Rw
- bus_ad_out  out  DATA_W  AddrData value driven by master
- bus_ad_oe  out  1  master drives AddrData when 1; the top level builds the tristate
- bus_ad_in  in  DATA_W  AddrData sampled from bus

Behaviour:
- Reset (resetN low, asynchronous):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_err, bus_addr_valid, bus_rw, bus_ad_oe = 0.
  - bus_ad_out and resp_rdata = 0; beat counter and latency counter = 0.
  - Reset mid-transaction abandons the burst; no response is produced.
- States: IDLE, ADDR, WAIT, DATA, RESP.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid & req_ready, latch rw, addr and wdata.
  - Go to ADDR.
- ADDR (exactly 1 cycle):
  - bus_addr_valid=1, bus_ad_oe=1, bus_ad_out=addr, bus_rw=rw.
  - Next state: DATA if write or READ_LAT==0; otherwise WAIT.
- WAIT:
  - bus_ad_oe=0; counts READ_LAT cycles, then goes to DATA.
- DATA (BURST_LEN cycles, beat counter 0..BURST_LEN-1):
  - Write: bus_ad_oe=1, bus_ad_out=wdata[beat].
  - Read: bus_ad_oe=0; bus_ad_in is registered into rdata[beat] at the clock edge ending each beat.
  - After the last beat, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - Next state is IDLE on resp_valid & resp_ready.
  - A new request cannot be accepted in the same cycle.
- bus_addr_valid is high for exactly one cycle per transaction.
- bus_rw holds the transaction's rw from ADDR through the last DATA beat, and is 0 otherwise.
- Latency:
  - Write: request accept to resp_valid = 1 + 1 + BURST_LEN cycles.
  - Read: request accept to resp_valid = 1 + 1 + READ_LAT + BURST_LEN cycles.
- The master sends only the base address. Address increment and page wrap are the slave's responsibility; unaligned bases are legal.
- req_valid asserted while not ready is ignored and does not need to be held stable.

Optional Feature:
- Macro: MAIN_BUS_MASTER_ADDR_CHECK_EN.
- Defined:
  - In IDLE, an accepted request whose addr[DATA_W-1:DATA_W-4] != MEM_PAGE skips the bus entirely and goes directly to RESP with resp_err=1 and resp_rdata=0.
  - Latency for a rejected request is 1 cycle.
  - Bus outputs stay 0 throughout.
- Undefined:
  - resp_err is tied 0; every request goes on the bus.

Decomposition:
- Shared package mcDefs additions:
  - state enum (IDLE, ADDR, WAIT, DATA, RESP)
  - DATA_W and BURST_LEN defaults
  - page-field width constant
  - typedef for a burst word array, logic [BURST_LEN-1:0][DATA_W-1:0]
- Sub-module: one natural sub-module, main_bus_beat_counter, a parameterized down-counter reused for the WAIT and DATA phases (load, enable, done flag).
- Everything else lives in one FSM module.

Test Plan:
- Write burst:
  - Stimulus: addr=16'h2010, wdata={16'hD,16'hC,16'hB,16'hA}.
  - Response: AddrValid pulse with AD=2010; then AD=A,B,C,D with oe=1 on 4 consecutive cycles; resp_valid 6 cycles after accept; resp_err=0.
- Read burst, READ_LAT=0:
  - Stimulus: slave drives 1111,2222,3333,4444 in the 4 cycles after the address cycle.
  - Response: resp_rdata words 0..3 equal those values; oe=0 during data.
- Read burst, READ_LAT=2:
  - Response: 2 idle cycles after the address cycle; data sampled only afterwards; resp_valid at 8 cycles after accept.
- Back-pressure:
  - Stimulus: hold resp_ready=0 for 5 cycles; pulse req_valid meanwhile.
  - Response: response is stable; req_ready=0; the second request is not accepted until after the response handshake.
- Reset mid-DATA:
  - Stimulus: assert resetN=0 asynchronously at beat 2.
  - Response: all outputs 0 immediately, req_ready=1; no resp_valid after release.
- With MAIN_BUS_MASTER_ADDR_CHECK_EN:
  - Stimulus: addr=16'h5000.
  - Response: resp_valid next cycle, resp_err=1, bus_addr_valid never asserted.
  - Control: addr=16'h2000 completes normally.
